bounce_renderer: RTL and testbench
==================================

BOUNCE_RENDERER -- requirements
Module: bounce_renderer

Interface
REQ-001 Parameter BALL_Y, default 7'd104, top row of the 4x4 ball sprite.
REQ-002 Parameter PLAT_Y0, default 7'd16, top row of platform lane 0.
REQ-003 Parameter LANE_PITCH, default 7'd24, row spacing between platform lanes.
REQ-004 Parameter PLAT_H, default 8, platform height in pixels (1 pixel wide).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to draw one frame from current updater outputs.
REQ-008 prev_ball  input  8  ball x to erase.
REQ-009 curr_ball  input  8  ball x to draw.
REQ-010 position_plats  input  32  platform k x = bits [8k+7:8k].
REQ-011 color_plats  input  12  platform k colour = bits [3k+2:3k].
REQ-012 color_ball  input  3  ball colour.
REQ-013 gameover  input  1  suppresses ball draw pass.
REQ-014 x  output  8  pixel column, valid when plot=1.
REQ-015 y  output  7  pixel row, valid when plot=1.
REQ-016 colour  output  3  pixel colour, valid when plot=1.
REQ-017 plot  output  1  write-enable to VGA adapter, one pixel per cycle.
REQ-018 busy  output  1  high from cycle after accepted start until done.
REQ-019 done  output  1  one-cycle pulse at frame completion.

Function
REQ-020 FSM states: IDLE, ERASE, PLATS, BALL, DONE; one pixel emitted per cycle in ERASE/PLATS/BALL.
- REQ-021 In IDLE, start=1 latches all data inputs; next state ERASE; latched values are used for the whole frame.
- REQ-022 start while busy=1 is ignored (no queue, no restart).
- REQ-023 ERASE: 16 pixels, colour 3'b000, x=prev_ball+dx, y=BALL_Y+dy, dx/dy 0..3, dx fastest.
- REQ-024 PLATS: lanes k=0..3 in order, each PLAT_H pixels, x=pos_k, y=PLAT_Y0+k*LANE_PITCH+r, r ascending, colour=color_plats slice k.
- REQ-025 BALL: as ERASE but x=curr_ball+dx, colour=color_ball; skipped (PLATS->DONE) when latched gameover=1.
- REQ-026 Latency: start accepted at cycle 0; plot cycles 1..64 (1..48 if gameover); done=1 on cycle 65 (49); IDLE next cycle.
- REQ-027 Clipping: any pixel with 9-bit sum x>=160 keeps plot=0 for that cycle; counters still advance; latency unchanged.
- REQ-028 Coordinate sums computed 9 bits wide; no wrap to low columns.
- REQ-029 start asserted in the DONE cycle is ignored; accepted from the following IDLE cycle.

Reset
REQ-030 resetn=0 at any clk edge, including mid-frame: state IDLE, all counters 0, plot=0, busy=0, done=0, x=0, y=0, colour=0.
REQ-031 A frame interrupted by reset is abandoned, never resumed.

Configuration
REQ-032 Macro RENDER_CLEAR_EN defined: state CLEAR (160x120=19200 pixels, colour 0, x fastest) precedes ERASE on first frame after reset and on every frame with gameover=1; done latency grows by 19200 cycles.
REQ-033 Macro undefined: CLEAR state and its counters absent; timing exactly as REQ-026.

Structure
REQ-034 Shared package holds the state enum, SCREEN_W=160, SCREEN_H=120, BALL_SIZE=4, NUM_PLATS=4.
REQ-035 One sub-module sprite_scan: generic counter emitting dx/dy for a WxH rectangle with last flag; instanced for ball and platform passes.

Verification
REQ-036 Reset then start with prev=10, curr=11, gameover=0 -> 64 plot cycles, first (10,104,000), pixel 17 (pos_0,16,plat0 colour), last (14,107,color_ball), done cycle 65.
REQ-037 gameover=1 -> 48 plot pulses, no pixel of colour color_ball at BALL_Y rows, done cycle 49.
REQ-038 curr_ball=158 -> ball pass plots dx 0,1 only (x=158,159); dx 2,3 plot=0; done still cycle 65.
REQ-039 start re-pulsed at cycles 5 and 65 -> both ignored; single done; next start accepted only at cycle 66 onward.
REQ-040 resetn low at cycle 30 -> next cycle plot=0, busy=0; new start yields full clean 64-pixel frame.
REQ-041 RENDER_CLEAR_EN build: first frame after reset -> 19200 black plots covering (0,0)..(159,119), then REQ-036 sequence, done cycle 19265.

Source files
------------

// File: rtl/bounce_renderer_pkg.sv
// bounce_renderer_pkg: shared types and screen/sprite geometry for the bounce renderer.
// Contents: state_e (frame sequencer states), SCREEN_W/SCREEN_H, BALL_SIZE, NUM_PLATS,
// CW (scan counter width). The CLEAR state exists only when RENDER_CLEAR_EN is defined.
package bounce_renderer_pkg;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int BALL_SIZE = 4;
    localparam int NUM_PLATS = 4;
    localparam int CW        = 8;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        PLATS,
        BALL,
        DONE
`ifdef RENDER_CLEAR_EN
        ,
        CLEAR
`endif
    } state_e;
endpackage

// File: rtl/bounce_renderer_sprite_scan.sv
// sprite_scan: raster counter over a W x H rectangle, dx fastest, wraps to 0 after the last cell.
// Ports: clk, resetn (sync active-low), en_i (advance one cell), dx_o/dy_o (current cell),
// last_o (current cell is the final one of the rectangle).
module sprite_scan
    import bounce_renderer_pkg::*;
#(
    parameter int W = 4,
    parameter int H = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en_i,
    output logic [CW-1:0] dx_o,
    output logic [CW-1:0] dy_o,
    output logic          last_o
);
    logic [CW-1:0] dx_q, dy_q;
    logic          end_x, end_y;

    assign end_x  = dx_q == CW'(W - 1);
    assign end_y  = dy_q == CW'(H - 1);
    assign last_o = end_x && end_y;
    assign dx_o   = dx_q;
    assign dy_o   = dy_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (en_i) begin
            dx_q <= end_x ? '0 : dx_q + CW'(1);
            if (end_x)
                dy_q <= end_y ? '0 : dy_q + CW'(1);
        end
    end
endmodule

// File: rtl/bounce_renderer.sv
// bounce_renderer: draws one game frame per start pulse, one pixel per cycle:
// erase old ball, draw 4 platforms, draw new ball (skipped on gameover).
// Ports: clk, resetn (sync active-low), start, prev_ball/curr_ball (ball x),
// position_plats/color_plats (4 platforms), color_ball, gameover -> x, y, colour, plot,
// busy, done. Optional macro RENDER_CLEAR_EN adds a full-screen black CLEAR pass before
// ERASE on the first frame after reset and on gameover frames.
module bounce_renderer
    import bounce_renderer_pkg::*;
#(
    parameter logic [6:0] BALL_Y     = 7'd104,
    parameter logic [6:0] PLAT_Y0    = 7'd16,
    parameter logic [6:0] LANE_PITCH = 7'd24,
    parameter int         PLAT_H     = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  prev_ball,
    input  logic [7:0]  curr_ball,
    input  logic [31:0] position_plats,
    input  logic [11:0] color_plats,
    input  logic [2:0]  color_ball,
    input  logic        gameover,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);
    state_e                         state_q, state_d;
    logic [7:0]                     prev_q, curr_q;
    logic [NUM_PLATS-1:0][7:0]      pos_q;
    logic [NUM_PLATS-1:0][2:0]      cp_q;
    logic [2:0]                     cb_q;
    logic                           gm_q;
    logic                           accept;
    logic [CW-1:0]                  ball_dx, ball_dy, plat_dx, plat_dy;
    logic                           ball_last, plat_last;
    logic [1:0]                     lane;
    logic [8:0]                     xs;
    logic                           pix;

    assign accept = state_q == IDLE && start;
    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;

    sprite_scan #(.W(BALL_SIZE), .H(BALL_SIZE)) u_ball (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (state_q == ERASE || state_q == BALL),
        .dx_o   (ball_dx),
        .dy_o   (ball_dy),
        .last_o (ball_last)
    );

    // dx walks the rows of one platform, dy selects the lane.
    sprite_scan #(.W(PLAT_H), .H(NUM_PLATS)) u_plat (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (state_q == PLATS),
        .dx_o   (plat_dx),
        .dy_o   (plat_dy),
        .last_o (plat_last)
    );

    assign lane = 2'(plat_dy);

`ifdef RENDER_CLEAR_EN
    logic [CW-1:0] clr_dx, clr_dy;
    logic          clr_last, first_q;

    sprite_scan #(.W(SCREEN_W), .H(SCREEN_H)) u_clr (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (state_q == CLEAR),
        .dx_o   (clr_dx),
        .dy_o   (clr_dy),
        .last_o (clr_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn)
            first_q <= 1'b1;
        else if (state_q == CLEAR)
            first_q <= 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q <= '0;
            curr_q <= '0;
            pos_q  <= '0;
            cp_q   <= '0;
            cb_q   <= '0;
            gm_q   <= 1'b0;
        end else if (accept) begin
            prev_q <= prev_ball;
            curr_q <= curr_ball;
            pos_q  <= position_plats;
            cp_q   <= color_plats;
            cb_q   <= color_ball;
            gm_q   <= gameover;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef RENDER_CLEAR_EN
            IDLE:  state_d = start ? ((first_q || gameover) ? CLEAR : ERASE) : IDLE;
            CLEAR: state_d = clr_last ? ERASE : CLEAR;
`else
            IDLE:  state_d = start ? ERASE : IDLE;
`endif
            ERASE: state_d = ball_last ? PLATS : ERASE;
            PLATS: state_d = plat_last ? (gm_q ? DONE : BALL) : PLATS;
            BALL:  state_d = ball_last ? DONE : BALL;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Column sums are 9 bits so sprites past the right edge clip instead of wrapping.
    always_comb begin
        xs     = '0;
        y      = '0;
        colour = '0;
        pix    = 1'b0;
        case (state_q)
            ERASE: begin
                xs  = {1'b0, prev_q} + 9'(ball_dx);
                y   = BALL_Y + 7'(ball_dy);
                pix = 1'b1;
            end
            PLATS: begin
                xs     = {1'b0, pos_q[lane]};
                y      = PLAT_Y0 + 7'(plat_dy) * LANE_PITCH + 7'(plat_dx);
                colour = cp_q[lane];
                pix    = 1'b1;
            end
            BALL: begin
                xs     = {1'b0, curr_q} + 9'(ball_dx);
                y      = BALL_Y + 7'(ball_dy);
                colour = cb_q;
                pix    = 1'b1;
            end
`ifdef RENDER_CLEAR_EN
            CLEAR: begin
                xs  = 9'(clr_dx);
                y   = 7'(clr_dy);
                pix = 1'b1;
            end
`endif
            default: ;
        endcase
        x    = xs[7:0];
        plot = pix && xs < 9'(SCREEN_W);
    end
endmodule

// File: tb/tb_bounce_renderer.sv
// tb_bounce_renderer: directed self-checking bench for bounce_renderer.
module tb_bounce_renderer;
`ifdef RENDER_CLEAR_EN
    localparam int CLR = 19200;
`else
    localparam int CLR = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn, start, gameover;
    logic [7:0]  prev_ball, curr_ball;
    logic [31:0] position_plats;
    logic [11:0] color_plats;
    logic [2:0]  color_ball;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    int   n_chk = 0;
    int   n_fail = 0;
    logic first = 1'b1;
    logic [7:0] sx[3];
    logic [6:0] sy[3];
    logic [2:0] sc[3];

    typedef struct packed {
        logic       p;
        logic [8:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    bounce_renderer dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .prev_ball      (prev_ball),
        .curr_ball      (curr_ball),
        .position_plats (position_plats),
        .color_plats    (color_plats),
        .color_ball     (color_ball),
        .gameover       (gameover),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected pixel for plot cycle c (1-based) with off leading clear cycles.
    function automatic pix_t model(input int c, input int off, input logic [7:0] pv, input logic [7:0] cu,
                                   input logic [31:0] pos, input logic [11:0] cp, input logic [2:0] cb);
        pix_t e;
        int i, k, xi;
        i = c - 1;
        e.c = 3'd0;
        if (i < off) begin
            xi  = i % 160;
            e.y = 7'(i / 160);
        end else begin
            i = i - off;
            if (i < 16) begin
                xi  = int'(pv) + i % 4;
                e.y = 7'(104 + i / 4);
            end else if (i < 48) begin
                k   = (i - 16) / 8;
                xi  = int'(pos[8*k +: 8]);
                e.y = 7'(16 + 24 * k + (i - 16) % 8);
                e.c = cp[3*k +: 3];
            end else begin
                xi  = int'(cu) + (i - 48) % 4;
                e.y = 7'(104 + (i - 48) / 4);
                e.c = cb;
            end
        end
        e.x = 9'(xi);
        e.p = xi < 160;
        return e;
    endfunction

    task automatic frame(input logic [7:0] pv, input logic [7:0] cu, input logic [31:0] pos,
                         input logic [11:0] cp, input logic [2:0] cb, input logic go,
                         input int exp_plots, input logic pulse);
        int off, total, plots;
        pix_t e;
        off   = (CLR != 0 && (first || go)) ? CLR : 0;
        first = 1'b0;
        total = off + (go ? 48 : 64);
        prev_ball = pv; curr_ball = cu; position_plats = pos;
        color_plats = cp; color_ball = cb; gameover = go;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        plots = 0;
        for (int c = 1; c <= total + 2; c++) begin
            if (c == 2) begin
                prev_ball = ~pv; curr_ball = ~cu; position_plats = ~pos;
                color_plats = ~cp; color_ball = ~cb; gameover = ~go;
            end
            start = pulse && (c == 5 || c == total + 1);
            @(negedge clk);
            if (c <= total) begin
                e = model(c, off, pv, cu, pos, cp, cb);
                check("plot", 32'(plot), 32'(e.p));
                if (e.p) begin
                    check("x", 32'(x), 32'(e.x));
                    check("y", 32'(y), 32'(e.y));
                    check("colour", 32'(colour), 32'(e.c));
                end
                check("busy_run", 32'(busy), 1);
                check("done_early", 32'(done), 0);
                plots += int'(plot);
            end else if (c == total + 1) begin
                check("done_pulse", 32'(done), 1);
                check("done_plot", 32'(plot), 0);
            end else begin
                check("done_low", 32'(done), 0);
                check("idle_busy", 32'(busy), 0);
            end
            for (int s = 0; s < 3; s++)
                if (c == off + (s == 0 ? 1 : s == 1 ? 17 : 64)) begin
                    sx[s] = x; sy[s] = y; sc[s] = colour;
                end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("plot_count", 32'(plots), 32'(exp_plots + off));
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; gameover = 1'b0;
        prev_ball = '0; curr_ball = '0; position_plats = '0; color_plats = '0; color_ball = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_plot", 32'(plot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_colour", 32'(colour), 0);
        @(posedge clk); #1;

        // pos = {80,60,40,20}, colours {5,4,3,2}
        frame(8'd10, 8'd11, 32'h503C2814, 12'hB1A, 3'd6, 1'b0, 64, 1'b0);
        check("first_x", 32'(sx[0]), 10);
        check("first_y", 32'(sy[0]), 104);
        check("first_c", 32'(sc[0]), 0);
        check("p17_x", 32'(sx[1]), 20);
        check("p17_y", 32'(sy[1]), 16);
        check("p17_c", 32'(sc[1]), 2);
        check("last_x", 32'(sx[2]), 14);
        check("last_y", 32'(sy[2]), 107);
        check("last_c", 32'(sc[2]), 6);

        // gameover: ball pass skipped
        frame(8'd30, 8'd31, 32'h9F780064, 12'h5C7, 3'd7, 1'b1, 48, 1'b0);
        // erase fully off-screen (255+dx, no wrap), ball clipped to dx 0,1
        frame(8'd255, 8'd158, 32'h01020304, 12'h249, 3'd5, 1'b0, 40, 1'b0);
        // start re-pulsed mid-frame and in DONE: ignored
        frame(8'd0, 8'd156, 32'h9F009F00, 12'hFFF, 3'd1, 1'b0, 64, 1'b1);

        // reset in the middle of a frame
        prev_ball = 8'd10; curr_ball = 8'd11; position_plats = 32'h503C2814;
        color_plats = 12'hB1A; color_ball = 3'd6; gameover = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        @(posedge clk); #1;
        resetn = 1'b1;
        first = 1'b1;
        @(negedge clk);
        check("mid_rst_plot", 32'(plot), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_x", 32'(x), 0);
        @(posedge clk); #1;
        frame(8'd10, 8'd11, 32'h503C2814, 12'hB1A, 3'd6, 1'b0, 64, 1'b0);
        check("re_first_x", 32'(sx[0]), 10);
        check("re_last_c", 32'(sc[2]), 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
